// File: rtl/s3g_tx.sv
// S3G packet framer: sends D5, length, payload, CRC8 (Maxim) to a byte UART.
// Latency: header tx_start the cycle after an accepted start; bytes follow back-to-back with UART completion.
// Backpressure: waits on tx_busy before each byte; stalls indefinitely while pl_valid is low.
module s3g_tx #(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND_HDR = 3'd1;
  localparam logic [2:0] SEND_LEN = 3'd2;
  localparam logic [2:0] SEND_PL  = 3'd3;
  localparam logic [2:0] SEND_CRC = 3'd4;
  localparam logic [2:0] FINISH   = 3'd5;

  // ISSUE waits for the UART to go idle (which is also completion of the previous byte);
  // GUARD is the tx_start cycle, before the UART has had a chance to raise tx_busy.
  localparam logic ISSUE = 1'b0;
  localparam logic GUARD = 1'b1;

  localparam logic [7:0] SYNC_BYTE = 8'hD5;
  localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

  logic [2:0] state;
  logic       phase;
  logic [7:0] len_q;
  logic [7:0] cnt;
  logic [7:0] crc;

  // Maxim/iButton CRC8 step for one byte, reflected poly 0x8C, fully unrolled.
  function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  // Payload is only pulled when the UART is free to take it this very cycle.
  always_comb begin
    pl_ready = (state == SEND_PL) && (phase == ISSUE) && !tx_busy;
  end

  // Framing FSM; all outward pulses are registered and default low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      phase    <= ISSUE;
      len_q    <= 8'h00;
      cnt      <= 8'h00;
      crc      <= 8'h00;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len > MAX_LEN_B) begin
              err <= 1'b1;
            end else begin
              len_q <= len;
              crc   <= 8'h00;
              cnt   <= 8'h00;
              busy  <= 1'b1;
              state <= SEND_HDR;
              // Launch the sync byte straight away when the UART is already free.
              if (!tx_busy) begin
                tx_data  <= SYNC_BYTE;
                tx_start <= 1'b1;
                phase    <= GUARD;
              end else begin
                phase <= ISSUE;
              end
            end
          end
        end
        SEND_HDR: begin
          if (phase == GUARD) begin
            phase <= ISSUE;
            state <= SEND_LEN;
          end else if (!tx_busy) begin
            tx_data  <= SYNC_BYTE;
            tx_start <= 1'b1;
            phase    <= GUARD;
          end
        end
        SEND_LEN: begin
          if (phase == GUARD) begin
            phase <= ISSUE;
            state <= (len_q == 8'h00) ? SEND_CRC : SEND_PL;
          end else if (!tx_busy) begin
            tx_data  <= len_q;
            tx_start <= 1'b1;
            phase    <= GUARD;
          end
        end
        SEND_PL: begin
          if (phase == GUARD) begin
            phase <= ISSUE;
            if (cnt == len_q) state <= SEND_CRC;
          end else if (pl_valid && pl_ready) begin
            tx_data  <= pl_data;
            tx_start <= 1'b1;
            crc      <= crc8(crc, pl_data);
            cnt      <= cnt + 8'd1;
            phase    <= GUARD;
          end
        end
        SEND_CRC: begin
          if (phase == GUARD) begin
            phase <= ISSUE;
            state <= FINISH;
          end else if (!tx_busy) begin
            tx_data  <= crc;
            tx_start <= 1'b1;
            phase    <= GUARD;
          end
        end
        FINISH: begin
          // The CRC byte is complete once the UART drops busy.
          if (!tx_busy) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          phase <= ISSUE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s3g_tx.sv
// Directed bench for s3g_tx with a 10-cycle UART model and a payload byte stream.
// Latency: n/a (testbench).
// Backpressure: UART model holds tx_busy for 10 cycles per byte; payload stream empties to stall.
module tb_s3g_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'h00;
  logic       busy, done, err, pl_ready, tx_start;
  logic [7:0] pl_data, tx_data;
  logic       pl_valid;
  logic       tx_busy = 1'b0;

  logic       pl_en = 1'b0;
  logic       pl_flush = 1'b0;
  logic [7:0] pl_mem [0:255];
  int         pl_wr = 0;
  int         pl_idx = 0;
  int         ucnt = 0;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] cap [0:255];
  int         cap_n = 0;
  int         n_done = 0, n_err = 0, n_rdy = 0;
  int         n_viol = 0, n_dbl = 0, n_busy_lo = 0;
  logic       prev_start = 1'b0;
  logic [7:0] exp_b [0:15];
  int         c0, d0, e0, r0, b0;

  s3g_tx #(.MAX_LEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .busy(busy), .done(done), .err(err),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Payload source: bytes queued in pl_mem, popped on each handshake.
  assign pl_valid = pl_en && (pl_idx < pl_wr);
  assign pl_data  = pl_mem[pl_idx[7:0]];

  always @(posedge clk) begin
    if (pl_flush) pl_idx <= pl_wr;
    else if (pl_valid && pl_ready) pl_idx <= pl_idx + 1;
  end

  // UART model: busy for 10 cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    if (!rst) begin
      ucnt <= 0; tx_busy <= 1'b0;
    end else if (tx_start) begin
      ucnt <= 10; tx_busy <= 1'b1;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else begin
      ucnt <= 0; tx_busy <= 1'b0;
    end
  end

  // Monitor just after each edge: capture launched bytes and protocol events.
  always begin
    @(posedge clk);
    #1;
    if (tx_start) begin
      cap[cap_n[7:0]] = tx_data;
      cap_n++;
      if (tx_busy) n_viol++;
      if (prev_start) n_dbl++;
      if (!busy) n_busy_lo++;
    end
    prev_start = tx_start;
    if (done) n_done++;
    if (err) n_err++;
    if (pl_ready) n_rdy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    pl_mem[pl_wr[7:0]] = b;
    pl_wr++;
  endtask

  task automatic go(input logic [7:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk(tag, done, 1);
    @(negedge clk);
  endtask

  task automatic wait_pl(input string tag, input int target);
    for (int i = 0; i < 400; i++) begin
      if (pl_idx == target) break;
      @(negedge clk);
    end
    chk(tag, pl_idx, target);
  endtask

  task automatic chk_bytes(input string tag, input int base, input int ne);
    chk({tag, "_count"}, cap_n - base, ne);
    for (int i = 0; i < ne; i++) chk({tag, "_byte"}, cap[(base + i) % 256], exp_b[i]);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("reset_outputs", {busy, done, err, pl_ready, tx_start, tx_data}, 0);
    rst = 1'b1;
    pl_en = 1'b1;
    tick(2);

    // len=3, payload 01 02 03, plus an ignored start mid-packet
    c0 = cap_n; d0 = n_done; e0 = n_err;
    push(8'h01); push(8'h02); push(8'h03);
    go(8'd3);
    chk("hdr_first_cycle", {busy, tx_start, tx_data}, {2'b11, 8'hD5});
    tick(30);
    go(8'd2);
    chk("busy_after_ignored_start", busy, 1);
    wait_done("pktA_done");
    tick(3);
    exp_b = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_bytes("pktA", c0, 6);
    chk("pktA_done_pulses", n_done - d0, 1);
    chk("pktA_no_err", n_err - e0, 0);
    chk("tx_data_held", tx_data, 8'hD8);
    chk("busy_low_after", busy, 0);

    // len=1, payload 01
    c0 = cap_n;
    push(8'h01);
    go(8'd1);
    wait_done("pktB_done");
    exp_b[0:3] = '{8'hD5, 8'h01, 8'h01, 8'h5E};
    chk_bytes("pktB", c0, 4);

    // len=0: no payload handshake at all
    c0 = cap_n; r0 = n_rdy;
    go(8'd0);
    wait_done("pktC_done");
    exp_b[0:2] = '{8'hD5, 8'h00, 8'h00};
    chk_bytes("pktC", c0, 3);
    chk("pktC_no_pl_ready", n_rdy - r0, 0);

    // Stall: only the first payload byte available for a while
    c0 = cap_n; b0 = pl_wr;
    push(8'h01);
    go(8'd3);
    wait_pl("stall_first_pop", b0 + 1);
    tick(20);
    chk("stall_no_tx", cap_n - c0, 3);
    push(8'h02); push(8'h03);
    wait_done("pktD_done");
    exp_b[0:5] = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    chk_bytes("pktD", c0, 6);

    // Oversize request rejected
    c0 = cap_n; e0 = n_err;
    go(8'd33);
    chk("err_pulse", {err, busy}, 2'b10);
    tick(1);
    chk("err_one_cycle", err, 0);
    tick(10);
    chk("err_count", n_err - e0, 1);
    chk("err_no_tx", cap_n - c0, 0);
    chk("err_busy_low", busy, 0);

    // Reset during the second payload byte
    b0 = pl_wr; d0 = n_done;
    push(8'h01); push(8'h02); push(8'h03);
    go(8'd3);
    wait_pl("abort_second_pop", b0 + 2);
    rst = 1'b0;
    tick(1);
    chk("abort_outputs", {busy, done, err, pl_ready, tx_start, tx_data}, 0);
    rst = 1'b1; pl_flush = 1'b1;
    tick(1);
    pl_flush = 1'b0;
    tick(30);
    chk("abort_no_done", n_done - d0, 0);
    c0 = cap_n;
    push(8'h01);
    go(8'd1);
    wait_done("pktE_done");
    exp_b[0:3] = '{8'hD5, 8'h01, 8'h01, 8'h5E};
    chk_bytes("pktE", c0, 4);

    // Back-to-back: second start in the cycle after done
    c0 = cap_n;
    push(8'h01); push(8'h02); push(8'h03); push(8'h01);
    go(8'd3);
    wait_done("b2b_first_done");
    go(8'd1);
    chk("b2b_second_hdr", {tx_start, tx_data}, {1'b1, 8'hD5});
    wait_done("b2b_second_done");
    exp_b[0:9] = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8, 8'hD5, 8'h01, 8'h01, 8'h5E};
    chk_bytes("b2b", c0, 10);

    // Whole-run protocol checks
    chk("tx_start_during_busy", n_viol, 0);
    chk("tx_start_multi_cycle", n_dbl, 0);
    chk("tx_start_while_not_busy", n_busy_lo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/s3g_tx.md
Name: s3g_tx

Overview:
- S3G packet framer/transmitter; the transmit-side counterpart of s3g_rx.
- On a start request, emits one packet to the byte-level UART transmitter in this order: start byte 0xD5, length byte, payload bytes, CRC8.
- Payload bytes are pulled from the host command/reply logic through a valid/ready stream.
- The CRC is computed on the fly over the payload bytes only.

Parameters:
- MAX_LEN, 32: maximum payload length in bytes. Any larger request is rejected.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low. Asserted when rst==0 at a clk rising edge.
- start  in  1  one-cycle request to send a packet; sampled only in IDLE.
- len  in  8  payload length, sampled together with start.
- busy  out  1  high from the accepted start until the done pulse.
- done  out  1  one-cycle pulse once the CRC byte has finished transmitting.
- err  out  1  one-cycle pulse when start is rejected because len > MAX_LEN.
- pl_data  in  8  payload byte from the host.
- pl_valid  in  1  pl_data is valid.
- pl_ready  out  1  block accepts pl_data this cycle; a transfer occurs when pl_valid && pl_ready.
- tx_data  out  8  byte to the UART transmitter; held stable while the UART is busy.
- tx_start  out  1  one-cycle pulse that launches the UART byte.
- tx_busy  in  1  UART busy; rises no later than the cycle after tx_start.

Behaviour:
- Reset (rst==0 at the edge): state goes to IDLE. busy, done, err, pl_ready and tx_start = 0; tx_data = 0x00; CRC = 0x00; byte counter = 0.
  - Reset applied mid-packet aborts the packet immediately. No done pulse is issued, and a partially sent packet is not completed.
- States: IDLE, SEND_HDR, SEND_LEN, SEND_PL, SEND_CRC, FINISH. Each SEND_* state has two phases:
  - ISSUE: wait for tx_busy==0, then register tx_data and pulse tx_start for one cycle.
  - GUARD: exactly one cycle after tx_start, during which tx_busy is ignored.
- Byte completion: a byte is complete at the first cycle with tx_busy==0 after GUARD. The next ISSUE may pulse tx_start in that same cycle, so there is no idle gap beyond the UART's own.
- IDLE, start && len <= MAX_LEN: latch len, clear CRC to 0x00, set busy=1, go to SEND_HDR.
  - tx_start=1 with tx_data=0xD5 in the cycle after start, provided tx_busy==0.
- IDLE, start && len > MAX_LEN: err=1 for the next cycle; stay in IDLE with busy=0.
- start while busy=1: ignored. No err pulse and no effect on the packet in flight.
- SEND_HDR: sends 0xD5, then goes to SEND_LEN.
- SEND_LEN: sends the latched len.
  - len==0: go straight to SEND_CRC.
  - Otherwise go to SEND_PL.
- SEND_PL:
  - pl_ready=1 only in ISSUE with tx_busy==0; it is 0 in every other state and phase.
  - On a transfer: tx_data<=pl_data; tx_start=1 next cycle; CRC<=crc8(CRC,pl_data); counter increments.
  - pl_valid low: the block stalls with no timeout.
  - After len transfers and completion of the last byte, go to SEND_CRC.
- crc8: Maxim/iButton CRC, reflected polynomial 0x8C, init 0x00, no final xor.
  - Per byte: c ^= d; then 8 iterations of c = c[0] ? (c>>1)^0x8C : c>>1.
  - Fully combinational (unrolled) and applied in the transfer cycle.
- SEND_CRC: sends the final CRC, then goes to FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
  - A start arriving in the cycle after done is accepted.
- The length byte and 0xD5 are never included in the CRC.
- tx_data holds its last value between bytes and after the packet ends.
- tx_start is never asserted while tx_busy==1, except inside GUARD, which cannot issue.

Test Plan:
- Idle UART (tx_busy models a 10-cycle byte time), start with len=3 and payload 01,02,03 offered with pl_valid held high -> tx_start bytes D5,03,01,02,03,D8, each tx_start pulse exactly one cycle and none during tx_busy; one done pulse after the sixth byte completes; busy high throughout.
- len=1, payload 0x01 -> D5,01,01,5E. len=0 -> D5,00,00 with pl_ready never asserted.
- len=3 with pl_valid deasserted for 20 cycles before the second payload byte -> transmission stalls with no tx_start during the gap; output is still D5,03,01,02,03,D8.
- len=MAX_LEN+1 (33) -> single err pulse, busy stays 0, no tx_start. start while busy -> ignored, packet unchanged, no err.
- rst=0 asserted during the second payload byte -> all outputs at reset values the next cycle, no done. New start with len=1, payload 0x01 -> clean D5,01,01,5E (CRC reinitialized).
- Back-to-back: start asserted in the cycle after done -> second packet begins with D5; both packets bit-exact.
